// File: rtl/k10_rf_wr_arbiter_if.sv
// Register-file write arbitration bus: pipeline WB request, long-latency unit result,
// register-file write port and pending-destination report.
interface k10_rf_wr_arbiter_if;
  // Handshakes: the WB request (i_wb_wr_en/addr/data) is held stable by its source while
  // o_wb_stall=1 and is consumed in any cycle with i_wb_wr_en=1 and o_wb_stall=0.
  // The LU result transfers on i_lu_valid && o_lu_ready; the source holds valid and
  // payload stable until that cycle.
  logic        i_wb_wr_en;
  logic [4:0]  i_wb_rd_addr;
  logic [31:0] i_wb_rd_data;
  logic        o_wb_stall;

  logic        i_lu_valid;
  logic [4:0]  i_lu_rd_addr;
  logic [31:0] i_lu_rd_data;
  logic        o_lu_ready;

  logic        o_rf_wr_en;
  logic [4:0]  o_rf_rd_addr;
  logic [31:0] o_rf_rd_data;

  logic        o_pend_valid;
  logic [4:0]  o_pend_addr;

  modport master (
    output i_wb_wr_en, i_wb_rd_addr, i_wb_rd_data,
    output i_lu_valid, i_lu_rd_addr, i_lu_rd_data,
    input  o_wb_stall, o_lu_ready,
    input  o_rf_wr_en, o_rf_rd_addr, o_rf_rd_data,
    input  o_pend_valid, o_pend_addr
  );

  modport slave (
    input  i_wb_wr_en, i_wb_rd_addr, i_wb_rd_data,
    input  i_lu_valid, i_lu_rd_addr, i_lu_rd_data,
    output o_wb_stall, o_lu_ready,
    output o_rf_wr_en, o_rf_rd_addr, o_rf_rd_data,
    output o_pend_valid, o_pend_addr
  );
endinterface

// File: rtl/k10_rf_wr_arbiter.sv
// Arbitrates the single register-file write port between the WB stage and a one-entry
// LU result buffer. Define K10_RF_ARB_FAIRNESS_EN to add the starvation counter and FORCE state.
module k10_rf_wr_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  k10_rf_wr_arbiter_if.slave   bus,
  output logic [1:0]           o_dbg_state
);

  if (STARVE_LIMIT < 2 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be in 2..15");
  end

`ifdef K10_RF_ARB_FAIRNESS_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1
  } state_t;
`endif

  state_t      state;
  logic        buf_valid;
  logic [4:0]  buf_addr;
  logic [31:0] buf_data;
  logic        rf_wr_en;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        same_rd;

`ifdef K10_RF_ARB_FAIRNESS_EN
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] cnt;
  logic [3:0] cnt_inc;
  assign cnt_inc = (cnt == 4'hF) ? cnt : cnt + 4'd1;
`endif

  // A younger pipeline write to the buffered destination makes the buffered value dead.
  assign same_rd = bus.i_wb_wr_en && (bus.i_wb_rd_addr == buf_addr) && (buf_addr != 5'd0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
      rf_wr_en  <= 1'b0;
      rf_addr   <= '0;
      rf_data   <= '0;
`ifdef K10_RF_ARB_FAIRNESS_EN
      cnt       <= '0;
`endif
    end else begin
      rf_wr_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.i_wb_wr_en) begin
            rf_wr_en <= (bus.i_wb_rd_addr != 5'd0);
            rf_addr  <= bus.i_wb_rd_addr;
            rf_data  <= bus.i_wb_rd_data;
          end
          if (bus.i_lu_valid && !buf_valid) begin
            buf_valid <= 1'b1;
            buf_addr  <= bus.i_lu_rd_addr;
            buf_data  <= bus.i_lu_rd_data;
            state     <= ST_PEND;
          end
`ifdef K10_RF_ARB_FAIRNESS_EN
          cnt <= '0;
`endif
        end

        ST_PEND: begin
          if (bus.i_wb_wr_en) begin
            rf_wr_en <= (bus.i_wb_rd_addr != 5'd0);
            rf_addr  <= bus.i_wb_rd_addr;
            rf_data  <= bus.i_wb_rd_data;
            if (same_rd) begin
              buf_valid <= 1'b0;
              buf_addr  <= '0;
              state     <= ST_IDLE;
`ifdef K10_RF_ARB_FAIRNESS_EN
              cnt       <= '0;
`endif
            end else begin
`ifdef K10_RF_ARB_FAIRNESS_EN
              cnt <= cnt_inc;
              if (cnt_inc == LIMIT) state <= ST_FORCE;
`endif
            end
          end else begin
            rf_wr_en  <= (buf_addr != 5'd0);
            rf_addr   <= buf_addr;
            rf_data   <= buf_data;
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            state     <= ST_IDLE;
`ifdef K10_RF_ARB_FAIRNESS_EN
            cnt       <= '0;
`endif
          end
        end

`ifdef K10_RF_ARB_FAIRNESS_EN
        // WB is stalled this cycle, so its held request is granted from IDLE next cycle.
        ST_FORCE: begin
          rf_wr_en  <= (buf_addr != 5'd0);
          rf_addr   <= buf_addr;
          rf_data   <= buf_data;
          buf_valid <= 1'b0;
          buf_addr  <= '0;
          state     <= ST_IDLE;
          cnt       <= '0;
        end
`endif

        default: begin
          state     <= ST_IDLE;
          buf_valid <= 1'b0;
          buf_addr  <= '0;
        end
      endcase
    end
  end

  assign bus.o_lu_ready   = !buf_valid;
`ifdef K10_RF_ARB_FAIRNESS_EN
  assign bus.o_wb_stall   = (state == ST_FORCE);
`else
  assign bus.o_wb_stall   = 1'b0;
`endif
  assign bus.o_pend_valid = buf_valid;
  assign bus.o_pend_addr  = buf_valid ? buf_addr : 5'd0;
  assign bus.o_rf_wr_en   = rf_wr_en;
  assign bus.o_rf_rd_addr = rf_addr;
  assign bus.o_rf_rd_data = rf_data;
  assign o_dbg_state      = state;

endmodule

// File: tb/tb_k10_rf_wr_arbiter.sv
// Bench for k10_rf_wr_arbiter: directed scenarios plus randomized traffic, checked by a
// queue-based reference model and a scoreboard monitor on the register-file write port.
module tb_k10_rf_wr_arbiter;

`ifdef K10_RF_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  localparam int LIMIT = 4;
  localparam int W     = 53;  // {cycle[15:0], addr[4:0], data[31:0]}

  logic i_clk = 1'b0;
  logic i_rst_n = 1'b0;
  logic [1:0] dbg_state;
  always #5 i_clk = ~i_clk;

  k10_rf_wr_arbiter_if bus();

  k10_rf_wr_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W-1:0]  exp_q[$];
  logic [36:0]   pend_q[$];   // model buffer: {addr, data}
  int            lost = 0;
  bit            force_now = 1'b0;
  bit            m_wb_taken = 1'b0;
  bit            m_lu_taken = 1'b0;
  logic [36:0]   head;
  logic [W-1:0]  e;
  bit            empty;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_write(input logic [4:0] a, input logic [31:0] d);
    if (a != 5'd0) exp_q.push_back({16'(cyc + 1), a, d});
  endfunction

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  // Reference model: evaluated mid-cycle on the inputs that the next rising edge will see.
  initial forever begin
    @(negedge i_clk);
    if (!i_rst_n) begin
      pend_q.delete();
      exp_q.delete();
      lost = 0;
      force_now = 1'b0;
      m_wb_taken = 1'b0;
      m_lu_taken = 1'b0;
      check("rst_rf_wr_en", 32'(bus.o_rf_wr_en), 32'd0);
      check("rst_rf_addr", 32'(bus.o_rf_rd_addr), 32'd0);
      check("rst_rf_data", bus.o_rf_rd_data, 32'd0);
      check("rst_pend_valid", 32'(bus.o_pend_valid), 32'd0);
      check("rst_pend_addr", 32'(bus.o_pend_addr), 32'd0);
      check("rst_lu_ready", 32'(bus.o_lu_ready), 32'd1);
      check("rst_wb_stall", 32'(bus.o_wb_stall), 32'd0);
    end else begin
      empty = (pend_q.size() == 0);
      head  = empty ? 37'd0 : pend_q[0];
      check("lu_ready", 32'(bus.o_lu_ready), 32'(empty));
      check("wb_stall", 32'(bus.o_wb_stall), 32'(force_now));
      check("pend_valid", 32'(bus.o_pend_valid), 32'(!empty));
      check("pend_addr", 32'(bus.o_pend_addr), 32'(head[36:32]));
      m_wb_taken = bus.i_wb_wr_en && !force_now;
      m_lu_taken = bus.i_lu_valid && empty;
      if (empty) begin
        if (bus.i_wb_wr_en) push_write(bus.i_wb_rd_addr, bus.i_wb_rd_data);
        if (bus.i_lu_valid) begin
          pend_q.push_back({bus.i_lu_rd_addr, bus.i_lu_rd_data});
          lost = 0;
        end
      end else if (force_now) begin
        push_write(head[36:32], head[31:0]);
        void'(pend_q.pop_front());
        lost = 0;
        force_now = 1'b0;
      end else if (bus.i_wb_wr_en) begin
        push_write(bus.i_wb_rd_addr, bus.i_wb_rd_data);
        if (bus.i_wb_rd_addr != 5'd0 && bus.i_wb_rd_addr == head[36:32]) begin
          void'(pend_q.pop_front());
          lost = 0;
        end else begin
          lost = (lost < 15) ? lost + 1 : 15;
          if (FAIR && lost >= LIMIT) force_now = 1'b1;
        end
      end else begin
        push_write(head[36:32], head[31:0]);
        void'(pend_q.pop_front());
        lost = 0;
      end
    end
  end

  // Scoreboard monitor on the register-file write port.
  initial forever begin
    @(negedge i_clk);
    if (i_rst_n) begin
      while (exp_q.size() > 0 && int'(exp_q[0][52:37]) < cyc) begin
        e = exp_q.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL rf_missed_write: got no write at cycle %0d, want addr %0d data 0x%0h",
                 int'(e[52:37]), e[36:32], e[31:0]);
      end
      if (bus.o_rf_wr_en) begin
        if (exp_q.size() > 0 && int'(exp_q[0][52:37]) == cyc) begin
          e = exp_q.pop_front();
          check("rf_addr", 32'(bus.o_rf_rd_addr), 32'(e[36:32]));
          check("rf_data", bus.o_rf_rd_data, e[31:0]);
        end else begin
          n_tests++;
          n_fail++;
          $display("FAIL rf_unexpected_write: got addr %0d data 0x%0h at cycle %0d, want no write",
                   bus.o_rf_rd_addr, bus.o_rf_rd_data, cyc);
        end
      end
    end
  end

  task automatic run_cycle(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic lv, input logic [4:0] la, input logic [31:0] ld);
    bus.i_wb_wr_en   = we;
    bus.i_wb_rd_addr = wa;
    bus.i_wb_rd_data = wd;
    bus.i_lu_valid   = lv;
    bus.i_lu_rd_addr = la;
    bus.i_lu_rd_data = ld;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) run_cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic pulse_reset();
    bus.i_wb_wr_en = 1'b0;
    bus.i_lu_valid = 1'b0;
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    int issued;
    int stalls;
    int guard;
    int dens;
    logic we, lv;
    logic [4:0] wa, la;
    logic [31:0] wd, ld;

    bus.i_wb_wr_en = 1'b0; bus.i_wb_rd_addr = '0; bus.i_wb_rd_data = '0;
    bus.i_lu_valid = 1'b0; bus.i_lu_rd_addr = '0; bus.i_lu_rd_data = '0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_dbg_state", 32'(dbg_state), 32'd0);
    i_rst_n = 1'b1;
    idle(1);

    // LU result with idle pipeline: buffered at edge 1, written after edge 2.
    run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
    check("x5_buffered", 32'(bus.o_pend_addr), 32'd5);
    idle(1);
    check("x5_wr_en", 32'(bus.o_rf_wr_en), 32'd1);
    check("x5_addr", 32'(bus.o_rf_rd_addr), 32'd5);
    check("x5_data", bus.o_rf_rd_data, 32'h1234);
    idle(2);

    // Starvation: buffered x6 against a continuous pipeline stream.
    run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h6666);
    issued = 0; stalls = 0; guard = 0;
    while (issued < 8 && guard < 40) begin
      run_cycle(1'b1, 5'(16 + issued), 32'hC000 + 32'(issued), 1'b0, 5'd0, 32'd0);
      guard++;
      if (m_wb_taken) issued++;
      else stalls++;
    end
    check("starve_issued", 32'(issued), 32'd8);
    check("starve_stalls", 32'(stalls), FAIR ? 32'd1 : 32'd0);
    check("starve_pend_after", 32'(bus.o_pend_valid), FAIR ? 32'd0 : 32'd1);
    idle(3);

    // Pipeline write to the buffered rd supersedes the buffer.
    run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hAA);
    check("x7_pend_valid", 32'(bus.o_pend_valid), 32'd1);
    run_cycle(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0);
    check("x7_pend_dropped", 32'(bus.o_pend_valid), 32'd0);
    check("x7_data", bus.o_rf_rd_data, 32'hBB);
    idle(3);

    // LU result to x0: buffered and consumed without a write.
    run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h3333);
    check("x0_pend_valid", 32'(bus.o_pend_valid), 32'd1);
    idle(1);
    check("x0_no_write", 32'(bus.o_rf_wr_en), 32'd0);
    check("x0_consumed", 32'(bus.o_lu_ready), 32'd1);
    idle(2);

    // Reset while the buffer is full.
    run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hDEAD);
    pulse_reset();
    check("rst_mid_lu_ready", 32'(bus.o_lu_ready), 32'd1);
    check("rst_mid_pend", 32'(bus.o_pend_valid), 32'd0);
    check("rst_mid_rf_addr", 32'(bus.o_rf_rd_addr), 32'd0);
    idle(3);

    // Buffer granted in the same cycle x9 arrives.
    run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 32'h88);
    bus.i_lu_rd_addr = 5'd9;
    bus.i_lu_rd_data = 32'h99;
    #1;
    check("x9_not_ready", 32'(bus.o_lu_ready), 32'd0);
    run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    check("x8_data", bus.o_rf_rd_data, 32'h88);
    run_cycle(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
    check("x9_buffered", 32'(bus.o_pend_addr), 32'd9);
    idle(1);
    check("x9_addr", 32'(bus.o_rf_rd_addr), 32'd9);
    check("x9_data", bus.o_rf_rd_data, 32'h99);
    idle(2);

    // Randomized traffic honouring both handshakes, in phases of varying pipeline load.
    we = 1'b0; lv = 1'b0; wa = '0; la = '0; wd = '0; ld = '0;
    for (int c = 0; c < 3000; c++) begin
      case (c / 500)
        0: dens = 50;
        1: dens = 95;
        2: dens = 100;
        3: dens = 20;
        4: dens = 80;
        default: dens = 60;
      endcase
      if (!(we && !m_wb_taken)) begin
        we = ($urandom_range(0, 99) < dens);
        wa = 5'($urandom_range(0, 7));
        wd = $urandom;
      end
      if (!(lv && !m_lu_taken)) begin
        lv = ($urandom_range(0, 99) < 30);
        la = 5'($urandom_range(0, 7));
        ld = $urandom;
      end
      run_cycle(we, wa, wd, lv, la, ld);
    end
    idle(6);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
